// File: rtl/fosfor_present_regif_if.sv
// rtl/fosfor_present_regif_if.sv - host nibble-bus interface for the PRESENT register block
interface fosfor_present_regif_if #(
    parameter int IO_W = 4
) ();
    logic [1:0]        Addr_ib;
    logic [IO_W-1:0]   Data_ib;
    logic [2*IO_W-1:0] Data_ob;

    modport master (output Addr_ib, output Data_ib, input Data_ob);
    modport slave  (input Addr_ib, input Data_ib, output Data_ob);
endinterface

// File: rtl/fosfor_present_regif.sv
// rtl/fosfor_present_regif.sv - PRESENT host register file, start/ready sequencer, status
// Optional address auto-increment: define PRESENT_AUTOINC_EN.
module fosfor_present_regif #(
    parameter int IO_W    = 4,
    parameter int BLOCK_W = 64,
    parameter int KEY_W   = 80
) (
    input  logic                  Clk_ik,
    input  logic                  Reset_irn,
    fosfor_present_regif_if.slave host,
    output logic [BLOCK_W-1:0]    PlainText_ob,
    output logic [KEY_W-1:0]      Key_ob,
    output logic                  Start_o,
    input  logic                  Ready_i,
    input  logic [BLOCK_W-1:0]    CipherText_ib
);
    localparam int RW = 2 * IO_W;
    localparam int NB = BLOCK_W / RW;
    localparam int NK = KEY_W / RW;

    localparam logic [7:0] A_STATUS = 8'h08;
    localparam logic [7:0] A_TEST   = 8'h09;
    localparam logic [7:0] A_KEY    = 8'h10;
    localparam logic [7:0] PT_END   = 8'(NB);
    localparam logic [7:0] KEY_END  = 8'(16 + NK);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WLO   = 2'd2;
    localparam logic [1:0] S_WHI   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               cmd_vld_q;
    logic [3:0]         cmd_q;
    logic [RW-1:0]      in_data_q;
    logic [7:0]         reg_addr_q, reg_addr_d;
    logic [BLOCK_W-1:0] pt_q;
    logic [KEY_W-1:0]   key_q;
    logic [BLOCK_W-1:0] cipher_q;
    logic [RW-1:0]      test_q;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [RW-1:0]      data_q;

    logic          rdy, busy;
    logic [RW-1:0] status;
    logic [RW-1:0] out_data;
    logic          cmd_clr, cmd_latch, cmd_wr, cmd_start;
    logic [7:0]    wr_addr;
    logic          pt_hit, key_hit;
    logic          start_ok, start_err, prot_drop, run_done;

    assign rdy    = (state_q == S_IDLE);
    assign busy   = !rdy;
    assign status = {{(RW-4){1'b0}}, err_q, done_q, busy, rdy};

    assign cmd_clr   = cmd_vld_q && (cmd_q == 4'b0000);
    assign cmd_latch = cmd_vld_q && cmd_q[0];
    assign cmd_wr    = cmd_vld_q && cmd_q[2];
    assign cmd_start = cmd_vld_q && cmd_q[3];

    // A latch in the same command redirects the write to the new address.
    assign wr_addr = cmd_latch ? 8'(in_data_q) : reg_addr_q;
    assign pt_hit  = (wr_addr < PT_END);
    assign key_hit = (wr_addr >= A_KEY) && (wr_addr < KEY_END);

    assign start_ok  = cmd_start && rdy;
    assign start_err = cmd_start && busy;
    assign prot_drop = cmd_wr && (pt_hit || key_hit) && busy;
    assign run_done  = (state_q == S_WHI) && Ready_i;

    always_comb begin
        reg_addr_d = wr_addr;
`ifdef PRESENT_AUTOINC_EN
        if (cmd_vld_q && (cmd_q[1] || cmd_q[2])) begin
            reg_addr_d = wr_addr + 8'd1;
        end
`else
        reg_addr_d = wr_addr;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_START;
            S_START: state_d = S_WLO;
            S_WLO:   if (!Ready_i) state_d = S_WHI;
            S_WHI:   if (Ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Clear is applied last so it wins over any status set in the same cycle.
    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (run_done) done_d = 1'b1;
        if (start_ok) done_d = 1'b0;
        if (start_err || prot_drop) err_d = 1'b1;
        if (cmd_clr) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
    end

    always_comb begin
        out_data = '0;
        if (reg_addr_q < PT_END) begin
            for (int i = 0; i < NB; i++) begin
                if (reg_addr_q == 8'(i)) out_data = cipher_q[i*RW +: RW];
            end
        end else if (reg_addr_q == A_STATUS) begin
            out_data = status;
        end else if (reg_addr_q == A_TEST) begin
            out_data = test_q;
        end
    end

    always_ff @(posedge Clk_ik) begin
        if (!Reset_irn) begin
            state_q    <= S_IDLE;
            cmd_vld_q  <= 1'b0;
            cmd_q      <= '0;
            in_data_q  <= '0;
            reg_addr_q <= '0;
            pt_q       <= '0;
            key_q      <= '0;
            cipher_q   <= '0;
            test_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cmd_vld_q  <= (host.Addr_ib == 2'b01);
            cmd_q      <= (host.Addr_ib == 2'b01) ? 4'(host.Data_ib) : 4'b0000;
            reg_addr_q <= reg_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (host.Addr_ib == 2'b10) in_data_q[IO_W-1:0]  <= host.Data_ib;
            if (host.Addr_ib == 2'b11) in_data_q[RW-1:IO_W] <= host.Data_ib;
            if (run_done) cipher_q <= CipherText_ib;
            if (cmd_wr && rdy) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_addr == 8'(i)) pt_q[i*RW +: RW] <= in_data_q;
                end
                for (int i = 0; i < NK; i++) begin
                    if (wr_addr == 8'(16 + i)) key_q[i*RW +: RW] <= in_data_q;
                end
            end
            if (cmd_wr && (wr_addr == A_TEST)) test_q <= in_data_q;
            data_q <= host.Addr_ib[1] ? out_data : status;
        end
    end

    assign host.Data_ob = data_q;
    assign PlainText_ob = pt_q;
    assign Key_ob       = key_q;
    assign Start_o      = (state_q == S_START);
endmodule

// File: tb/tb_fosfor_present_regif.sv
// tb/tb_fosfor_present_regif.sv - scoreboard bench for fosfor_present_regif with a behavioural core
module tb_fosfor_present_regif;
    localparam int IO_W    = 4;
    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;
    localparam int NB      = 8;
    localparam int NK      = 10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fosfor_present_regif_if #(.IO_W(IO_W)) host ();
    logic [BLOCK_W-1:0] pt_o;
    logic [KEY_W-1:0]   key_o;
    logic               start_o;
    logic               ready_i;
    logic [BLOCK_W-1:0] ct_i;

    fosfor_present_regif #(.IO_W(IO_W), .BLOCK_W(BLOCK_W), .KEY_W(KEY_W)) dut (
        .Clk_ik        (clk),
        .Reset_irn     (rstn),
        .host          (host),
        .PlainText_ob  (pt_o),
        .Key_ob        (key_o),
        .Start_o       (start_o),
        .Ready_i       (ready_i),
        .CipherText_ib (ct_i)
    );

    typedef struct {
        int           kind;
        logic [127:0] exp;
    } chk_t;

    chk_t  exp_q[$];
    string name_q[$];
    logic  chk_req = 1'b0;
    logic  chk_pend = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    start_cnt = 0;
    chk_t  mc;
    string mn;
    logic [127:0] act;

    logic [7:0] m_pt[NB];
    logic [7:0] m_key[NK];
    logic [7:0] m_ct[NB];
    logic [7:0] m_test, m_addr, m_in;
    bit         m_done, m_err, m_busy;
    int         m_starts = 0;

    int core_lat = 4;
    bit core_fin = 1'b0;

    always @(posedge clk) chk_pend <= chk_req;
    always @(posedge clk) if (start_o) start_cnt <= start_cnt + 1;

    // Monitor: one queued expectation per flagged cycle.
    always @(negedge clk) begin
        if (chk_pend) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow got=empty want=entry");
            end else begin
                mc = exp_q.pop_front();
                mn = name_q.pop_front();
                case (mc.kind)
                    0:       act = 128'(host.Data_ob);
                    1:       act = 128'(key_o);
                    2:       act = 128'(pt_o);
                    3:       act = 128'(start_cnt);
                    default: act = 128'(start_o);
                endcase
                if (act !== mc.exp) begin
                    bad++;
                    $display("FAIL %s got=%0h want=%0h", mn, act, mc.exp);
                end
            end
        end
    end

    // Behavioural core: drops ready after a start, returns a random block later.
    initial begin
        ready_i = 1'b1;
        ct_i    = '0;
        forever begin
            @(negedge clk);
            if (start_o) begin
                ready_i = 1'b0;
                repeat (core_lat) @(negedge clk);
                ct_i     = {$urandom, $urandom};
                ready_i  = 1'b1;
                core_fin = 1'b1;
            end
        end
    end

    function automatic logic [7:0] m_status();
        return {4'b0000, m_err, m_done, m_busy, !m_busy};
    endfunction

    function automatic logic [7:0] m_out();
        int a = int'(m_addr);
        if (a < NB) return m_ct[a];
        if (a == 8) return m_status();
        if (a == 9) return m_test;
        return 8'h00;
    endfunction

    function automatic logic [127:0] m_keyv();
        logic [127:0] v = '0;
        for (int i = 0; i < NK; i++) v[i*8 +: 8] = m_key[i];
        return v;
    endfunction

    function automatic logic [127:0] m_ptv();
        logic [127:0] v = '0;
        for (int i = 0; i < NB; i++) v[i*8 +: 8] = m_pt[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin m_pt[i] = 8'h00; m_ct[i] = 8'h00; end
        for (int i = 0; i < NK; i++) m_key[i] = 8'h00;
        m_test = 8'h00; m_addr = 8'h00; m_in = 8'h00;
        m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_cmd(input logic [3:0] c);
        logic [7:0] base;
        int b;
        if (c == 4'b0000) begin
            m_done = 1'b0;
            m_err  = 1'b0;
            return;
        end
        base   = c[0] ? m_in : m_addr;
        m_addr = base;
        b      = int'(base);
        if (c[2]) begin
            if (b < NB) begin
                if (m_busy) m_err = 1'b1; else m_pt[b] = m_in;
            end else if (b == 9) begin
                m_test = m_in;
            end else if (b >= 16 && b < 16 + NK) begin
                if (m_busy) m_err = 1'b1; else m_key[b-16] = m_in;
            end
        end
`ifdef PRESENT_AUTOINC_EN
        if (c[1] || c[2]) m_addr = base + 8'd1;
`endif
        if (c[3]) begin
            if (m_busy) m_err = 1'b1;
            else begin
                m_busy = 1'b1;
                m_done = 1'b0;
                m_starts++;
            end
        end
    endtask

    task automatic step(input logic [1:0] a, input logic [3:0] d);
        host.Addr_ib = a;
        host.Data_ib = d;
        @(negedge clk);
        chk_req = 1'b0;
    endtask

    task automatic expect_chk(input int kind, input logic [127:0] e, input string name);
        exp_q.push_back('{kind: kind, exp: e});
        name_q.push_back(name);
        chk_req = 1'b1;
    endtask

    task automatic rd_status(input string name);
        expect_chk(0, 128'(m_status()), name);
        step(2'b00, 4'h0);
    endtask

    task automatic rd_out(input string name);
        expect_chk(0, 128'(m_out()), name);
        step(2'b10, m_in[3:0]);
    endtask

    task automatic set_in(input logic [7:0] v);
        step(2'b10, v[3:0]);
        step(2'b11, v[7:4]);
        m_in = v;
    endtask

    task automatic cmd(input logic [3:0] c);
        step(2'b01, c);
        step(2'b00, 4'h0);
        model_cmd(c);
    endtask

    task automatic wait_core(input string name);
        int n = 0;
        while (!core_fin && n < 300) begin
            step(2'b00, 4'h0);
            n++;
        end
        if (!core_fin) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=no_ready want=ready", name);
        end
        step(2'b00, 4'h0);
        step(2'b00, 4'h0);
    endtask

    task automatic start_run(input int lat);
        core_fin = 1'b0;
        core_lat = lat;
        cmd(4'h8);
        rd_status("run_busy");
    endtask

    task automatic finish_run(input string name);
        wait_core(name);
        m_busy = 1'b0;
        m_done = 1'b1;
        for (int i = 0; i < NB; i++) m_ct[i] = ct_i[i*8 +: 8];
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 8'($urandom_range(0, NB - 1));
            1:       return 8'(16 + $urandom_range(0, NK - 1));
            2:       return 8'($urandom_range(8, 9));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        host.Addr_ib = 2'b00;
        host.Data_ib = 4'h0;
        model_reset();
        @(negedge clk);

        // reset with a write attempt on the bus
        rstn = 1'b0;
        expect_chk(0, 128'h0, "rst_data");
        step(2'b10, 4'hF);
        expect_chk(4, 128'h0, "rst_start");
        step(2'b10, 4'hF);
        rstn = 1'b1;
        rd_status("rst_status");

        // full run with zero plaintext and key
        start_run(12);
        finish_run("run0");
        rd_status("run0_done");
        for (int i = 0; i < NB; i++) begin
            set_in(8'(i));
            cmd(4'h1);
            rd_out("run0_ct");
        end

        // busy protection
        set_in(8'h00);
        cmd(4'h1);
        set_in(8'hAA);
        start_run(40);
        cmd(4'h4);
        rd_status("busy_err");
        cmd(4'h8);
        rd_status("busy_restart");
        expect_chk(2, m_ptv(), "busy_pt_kept");
        step(2'b00, 4'h0);
        cmd(4'h0);
        rd_status("busy_clear");
        finish_run("run1");
        rd_status("run1_done");
        expect_chk(3, 128'(m_starts), "start_count");
        step(2'b00, 4'h0);

        // address auto-increment across the key range and 8-bit wrap
        set_in(8'h10);
        cmd(4'h1);
        for (int i = 0; i < 10; i++) begin
            set_in(8'(8'h11 + i));
            cmd(4'h4);
        end
        expect_chk(1, m_keyv(), "autoinc_key");
        step(2'b00, 4'h0);
        rd_out("autoinc_rd");
        set_in(8'hFF);
        cmd(4'h5);
        rd_out("autoinc_wrap");

        // test register and unmapped/write-only reads
        set_in(8'h09);
        cmd(4'h1);
        set_in(8'h5A);
        cmd(4'h4);
        set_in(8'h09);
        cmd(4'h1);
        rd_out("test_reg");
        set_in(8'h30);
        cmd(4'h1);
        rd_out("unmapped");
        set_in(8'h12);
        cmd(4'h1);
        rd_out("key_wo");

        // randomised traffic
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    set_in(pick_addr());
                    cmd(4'h1);
                    rd_out("rnd_latch_rd");
                end
                3, 4, 5: begin
                    v = 8'($urandom_range(0, 255));
                    set_in(v);
                    cmd(4'($urandom_range(2, 7)));
                    rd_out("rnd_cmd_rd");
                end
                6: begin
                    expect_chk(1, m_keyv(), "rnd_key");
                    step(2'b00, 4'h0);
                    expect_chk(2, m_ptv(), "rnd_pt");
                    step(2'b00, 4'h0);
                end
                7: rd_status("rnd_status");
                8: begin
                    start_run($urandom_range(4, 12));
                    finish_run("rnd_run");
                    rd_status("rnd_run_done");
                end
                default: begin
                    cmd(4'h0);
                    rd_status("rnd_clear");
                end
            endcase
        end

        // reset during a run aborts it; the late ready is ignored
        start_run(20);
        step(2'b00, 4'h0);
        rstn = 1'b0;
        step(2'b00, 4'h0);
        rstn = 1'b1;
        model_reset();
        wait_core("abort");
        rd_status("abort_status");
        expect_chk(2, m_ptv(), "abort_pt");
        step(2'b00, 4'h0);
        expect_chk(3, 128'(m_starts), "final_starts");
        step(2'b00, 4'h0);
        step(2'b00, 4'h0);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
